iig_param: RTL and testbench

//   Parametrised integral-image generator for the face-detection front end. Consumes a raster

---
 rtl/iig_param.sv | 159 +++++++++++++++
 tb/tb_iig_param.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iig_param.sv
// Integral-image generator: turns a raster stream of grey pixels into
// integral (and optionally squared-integral) BRAM writes, one word per pixel.
// A one-row line buffer holds the previous row's integrals.
//
// Handshake: iInput_ready qualifies iData for one cycle with no back-pressure.
// A pixel counts as accepted only in ACCUM. Each accepted pixel produces
// exactly one registered write (oWrreq_to_IIGBRAM=1) on the following cycle.
module iig_param #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int PIX_W = 8,
   parameter int SQ_EN = 1,
   localparam int ADDR_W = $clog2(IMG_W * IMG_H),
   localparam int SUM_W  = PIX_W + $clog2(IMG_W) + $clog2(IMG_H),
   localparam int SQ_W   = 2 * PIX_W + $clog2(IMG_W) + $clog2(IMG_H)
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic              iRun,
   input  logic              iInput_ready,
   input  logic [PIX_W-1:0]  iData,
   output logic              oBusy,
   output logic              oDone,
   output logic              oWrreq_to_IIGBRAM,
   output logic [ADDR_W-1:0] oAddr_to_IIGBRAM,
   output logic [SUM_W-1:0]  oData,
   output logic [SQ_W-1:0]   oSqData,
   output logic [1:0]        state_dbg
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [XW-1:0]     x_q;
   logic [YW-1:0]     y_q;
   logic [ADDR_W-1:0] addr_q;
   logic [SUM_W-1:0]  rs_q;
   logic [SUM_W-1:0]  lb [IMG_W];

   logic              accept;
   logic              start;
   logic              x_last;
   logic              frame_last;
   logic [SUM_W-1:0]  rs_sum;
   logic [SUM_W-1:0]  ii;

   assign accept     = (state_q == ACCUM) && iInput_ready;
   assign start      = (state_q == IDLE) && iRun;
   assign x_last     = (x_q == X_LAST);
   assign frame_last = accept && x_last && (y_q == Y_LAST);
   assign rs_sum     = rs_q + SUM_W'(iData);
   // Row 0 never adds the line buffer, which masks stale data from the previous frame.
   assign ii         = rs_sum + ((y_q == '0) ? '0 : lb[x_q]);

   assign oBusy      = (state_q != IDLE);
   assign state_dbg  = state_q;

   // State register.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: iRun only matters in IDLE; DONE lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (iRun) state_d = ACCUM;
         ACCUM:   if (frame_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Raster position, row sum and registered write port.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         x_q               <= '0;
         y_q               <= '0;
         addr_q            <= '0;
         rs_q              <= '0;
         oWrreq_to_IIGBRAM <= 1'b0;
         oDone             <= 1'b0;
         oAddr_to_IIGBRAM  <= '0;
         oData             <= '0;
      end else begin
         oWrreq_to_IIGBRAM <= accept;
         oDone             <= frame_last;
         if (start) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
            rs_q   <= '0;
         end else if (accept) begin
            oAddr_to_IIGBRAM <= addr_q;
            oData            <= ii;
            addr_q           <= addr_q + ADDR_W'(1);
            if (x_last) begin
               x_q  <= '0;
               y_q  <= y_q + YW'(1);
               rs_q <= '0;
            end else begin
               x_q  <= x_q + XW'(1);
               rs_q <= rs_sum;
            end
         end
      end
   end

   // Line buffer update; contents deliberately survive reset.
   always_ff @(posedge iClk) begin
      if (accept) lb[x_q] <= ii;
   end

   generate
      if (SQ_EN != 0) begin : g_sq
         logic [SQ_W-1:0]      lbsq [IMG_W];
         logic [SQ_W-1:0]      rsq_q;
         logic [2*PIX_W-1:0]   p_sq;
         logic [SQ_W-1:0]      rsq_sum;
         logic [SQ_W-1:0]      sq;

         assign p_sq    = {{PIX_W{1'b0}}, iData} * {{PIX_W{1'b0}}, iData};
         assign rsq_sum = rsq_q + SQ_W'(p_sq);
         assign sq      = rsq_sum + ((y_q == '0) ? '0 : lbsq[x_q]);

         // Squared row sum and squared-integral output.
         always_ff @(posedge iClk or posedge iReset) begin
            if (iReset) begin
               rsq_q   <= '0;
               oSqData <= '0;
            end else if (start) begin
               rsq_q <= '0;
            end else if (accept) begin
               oSqData <= sq;
               rsq_q   <= x_last ? '0 : rsq_sum;
            end
         end

         // Squared line buffer update.
         always_ff @(posedge iClk) begin
            if (accept) lbsq[x_q] <= sq;
         end
      end else begin : g_nosq
         assign oSqData = '0;
      end
   endgenerate

endmodule

// File: tb/tb_iig_param.sv
// Bench for iig_param on a 4x3 window: table of frames with hand-computed
// spot values, a per-write scoreboard fed by a direct double-sum model,
// plus a hand-written mid-frame reset sequence. A second instance with the
// squared path disabled runs on the same stimulus.
module tb_iig_param;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic clk = 1'b0;
   logic iReset = 1'b1;
   logic iRun = 1'b0;
   logic iInput_ready = 1'b0;
   logic [7:0] iData = '0;

   logic        oBusy, oDone, oWrreq;
   logic [3:0]  oAddr;
   logic [11:0] oData;
   logic [19:0] oSqData;
   logic [1:0]  st;

   logic        busy_n, done_n, wr_n;
   logic [3:0]  addr_n;
   logic [11:0] data_n;
   logic [19:0] sq_n;
   logic [1:0]  st_n;

   iig_param #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .SQ_EN(1)) dut (
      .iClk(clk), .iReset(iReset), .iRun(iRun), .iInput_ready(iInput_ready), .iData(iData),
      .oBusy(oBusy), .oDone(oDone), .oWrreq_to_IIGBRAM(oWrreq), .oAddr_to_IIGBRAM(oAddr),
      .oData(oData), .oSqData(oSqData), .state_dbg(st));

   iig_param #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .SQ_EN(0)) dut_nosq (
      .iClk(clk), .iReset(iReset), .iRun(iRun), .iInput_ready(iInput_ready), .iData(iData),
      .oBusy(busy_n), .oDone(done_n), .oWrreq_to_IIGBRAM(wr_n), .oAddr_to_IIGBRAM(addr_n),
      .oData(data_n), .oSqData(sq_n), .state_dbg(st_n));

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // scoreboard
   logic [3:0]  exp_addr_q[$];
   logic [11:0] exp_data_q[$];
   logic [19:0] exp_sq_q[$];
   logic        exp_done_q[$];

   int          pix[N];
   logic [11:0] cap_data[N];
   logic [19:0] cap_sq[N];
   logic        pend_wr = 1'b0;
   logic        done_seen = 1'b0;
   logic        prev_done = 1'b0;
   int          frame_writes = 0;

   // Reference: ii(x,y) as a direct double sum over the pixel array.
   task automatic push_exp(input int n);
      for (int a = 0; a < n; a++) begin
         int x, y, s, q;
         x = a % W;
         y = a / W;
         s = 0;
         q = 0;
         for (int j = 0; j <= y; j++)
            for (int i = 0; i <= x; i++) begin
               s += pix[j*W+i];
               q += pix[j*W+i] * pix[j*W+i];
            end
         exp_addr_q.push_back(4'(a));
         exp_data_q.push_back(12'(s));
         exp_sq_q.push_back(20'(q));
         exp_done_q.push_back(a == N - 1);
      end
   endtask

   // Write monitor: sampled 1 time unit after every rising edge.
   always @(posedge clk) begin : mon
      logic ew;
      ew = pend_wr;
      #1;
      check("wrreq", oWrreq, ew);
      check("wrreq_nosq", wr_n, ew);
      check("sq_disabled", sq_n, 0);
      if (prev_done) check("busy_fall", oBusy, 0);
      prev_done = oDone;
      if (oWrreq) begin
         check("write_expected", 32'(exp_addr_q.size() != 0), 1);
         if (exp_addr_q.size() != 0) begin
            logic [3:0]  ea;
            logic [11:0] ed;
            logic [19:0] es;
            logic        edn;
            ea  = exp_addr_q.pop_front();
            ed  = exp_data_q.pop_front();
            es  = exp_sq_q.pop_front();
            edn = exp_done_q.pop_front();
            check("addr", oAddr, ea);
            check("data", oData, ed);
            check("sqdata", oSqData, es);
            check("done", oDone, edn);
            check("addr_nosq", addr_n, ea);
            check("data_nosq", data_n, ed);
            check("done_nosq", done_n, edn);
         end
         frame_writes++;
         if (oAddr < 4'(N)) begin
            cap_data[oAddr] = oData;
            cap_sq[oAddr]   = oSqData;
         end
         if (oDone) begin
            check("busy_at_done", oBusy, 1);
            done_seen = 1'b1;
         end
      end
   end

   // driver tasks
   task automatic start_frame(input int noise);
      if (noise != 0) begin
         // Pixels offered while IDLE must not produce writes.
         repeat (3) begin
            @(negedge clk);
            iInput_ready = 1'b1;
            iData        = 8'd99;
            pend_wr      = 1'b0;
         end
      end
      @(negedge clk);
      iInput_ready = 1'b0;
      iRun         = 1'b1;
      @(negedge clk);
      iRun = 1'b0;
      check("busy_after_run", oBusy, 1);
      frame_writes = 0;
      done_seen    = 1'b0;
      for (int i = 0; i < N; i++) begin
         cap_data[i] = '0;
         cap_sq[i]   = '0;
      end
   endtask

   task automatic drive_pixels(input int n, input int gap_max, input int noise);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, gap_max)) begin
            @(negedge clk);
            iInput_ready = 1'b0;
            pend_wr      = 1'b0;
         end
         @(negedge clk);
         iData        = 8'(pix[k]);
         iInput_ready = 1'b1;
         pend_wr      = 1'b1;
         iRun         = (noise != 0) && (k == 5);
      end
      @(negedge clk);
      iInput_ready = 1'b0;
      pend_wr      = 1'b0;
      // A stray iRun during the DONE cycle must be ignored too.
      iRun         = (noise != 0);
   endtask

   task automatic finish_frame();
      @(negedge clk);
      iRun = 1'b0;
      for (int c = 0; c < 40 && !done_seen; c++) @(negedge clk);
      check("done_timeout", done_seen, 1);
      repeat (2) @(negedge clk);
      check("frame_writes", frame_writes, N);
      check("queue_empty", exp_addr_q.size(), 0);
      check("idle_after_frame", oBusy, 0);
   endtask

   typedef struct {
      int ramp;
      int val;
      int gap_max;
      int noise;
      int chk_addr;
      int exp_data;
      int exp_sq;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{ramp: 0, val: 1,   gap_max: 0, noise: 0, chk_addr: 11, exp_data: 12,   exp_sq: 12};
      tbl[1] = '{ramp: 0, val: 255, gap_max: 3, noise: 0, chk_addr: 11, exp_data: 3060, exp_sq: 780300};
      tbl[2] = '{ramp: 0, val: 3,   gap_max: 1, noise: 0, chk_addr: 5,  exp_data: 12,   exp_sq: 36};
      tbl[3] = '{ramp: 0, val: 3,   gap_max: 0, noise: 0, chk_addr: 11, exp_data: 36,   exp_sq: 108};
      tbl[4] = '{ramp: 0, val: 200, gap_max: 2, noise: 0, chk_addr: 11, exp_data: 2400, exp_sq: 480000};
      tbl[5] = '{ramp: 1, val: 0,   gap_max: 0, noise: 0, chk_addr: 3,  exp_data: 6,    exp_sq: 14};
      tbl[6] = '{ramp: 0, val: 1,   gap_max: 1, noise: 1, chk_addr: 11, exp_data: 12,   exp_sq: 12};

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", oBusy, 0);
      check("rst_done", oDone, 0);
      check("rst_wrreq", oWrreq, 0);
      check("rst_addr", oAddr, 0);
      check("rst_data", oData, 0);
      check("rst_sq", oSqData, 0);
      check("rst_state", st, 0);
      iReset = 1'b0;
      @(negedge clk);

      // table-driven frames
      for (int v = 0; v < 7; v++) begin
         for (int a = 0; a < N; a++) pix[a] = (tbl[v].ramp != 0) ? a : tbl[v].val;
         push_exp(N);
         start_frame(tbl[v].noise);
         drive_pixels(N, tbl[v].gap_max, tbl[v].noise);
         finish_frame();
         check($sformatf("spot_data_v%0d", v), cap_data[tbl[v].chk_addr], tbl[v].exp_data);
         check($sformatf("spot_sq_v%0d", v), cap_sq[tbl[v].chk_addr], tbl[v].exp_sq);
      end

      // reset after 7 pixels of an all-ones frame
      for (int a = 0; a < N; a++) pix[a] = 1;
      push_exp(7);
      start_frame(0);
      drive_pixels(7, 0, 0);
      #2 iReset = 1'b1;
      @(negedge clk);
      iRun = 1'b0;
      check("mid_rst_busy", oBusy, 0);
      check("mid_rst_wrreq", oWrreq, 0);
      check("mid_rst_done", oDone, 0);
      check("mid_rst_addr", oAddr, 0);
      check("mid_rst_data", oData, 0);
      check("mid_rst_sq", oSqData, 0);
      check("mid_rst_state", st, 0);
      check("mid_rst_writes", frame_writes, 7);
      check("mid_rst_queue", exp_addr_q.size(), 0);
      @(negedge clk);
      iReset = 1'b0;
      repeat (2) @(negedge clk);
      check("post_rst_no_write", frame_writes, 7);

      // restart reproduces the all-ones frame from address 0
      push_exp(N);
      start_frame(0);
      drive_pixels(N, 0, 0);
      finish_frame();
      check("restart_addr11", cap_data[11], 12);
      check("restart_addr5", cap_data[5], 4);
      check("restart_addr0", cap_data[0], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
